// File: rtl/mlp_main.sv
// mlp_main
// Fixed-point feed-forward neural network core: 7 inputs, a per-input
// scaling layer, 13 ReLU hidden neurons and one linear output neuron.
// Every 17-bit value is sign-magnitude: bit 16 is the sign, bits 15:0 are
// an unsigned Q8.8 magnitude. A new input vector (inputs and all weights)
// is accepted every clock, and its result appears three edges later.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, clears every pipeline stage
//   x1..x7       network inputs
//   w1..w7       input-layer weights, wi scales xi
//   w2_1..w2_13  hidden-neuron weights, lane j (bits 17*j+16:17*j) weighs
//                input-layer output j+1
//   w_3          output-neuron weights, lane k weighs hidden neuron k+1
//   y            network output
//   y_valid      high once y holds a result computed from sampled inputs

module mlp_main (
  input  logic         clk,
  input  logic         rst,
  input  logic [16:0]  x1,
  input  logic [16:0]  x2,
  input  logic [16:0]  x3,
  input  logic [16:0]  x4,
  input  logic [16:0]  x5,
  input  logic [16:0]  x6,
  input  logic [16:0]  x7,
  input  logic [16:0]  w1,
  input  logic [16:0]  w2,
  input  logic [16:0]  w3,
  input  logic [16:0]  w4,
  input  logic [16:0]  w5,
  input  logic [16:0]  w6,
  input  logic [16:0]  w7,
  input  logic [118:0] w2_1,
  input  logic [118:0] w2_2,
  input  logic [118:0] w2_3,
  input  logic [118:0] w2_4,
  input  logic [118:0] w2_5,
  input  logic [118:0] w2_6,
  input  logic [118:0] w2_7,
  input  logic [118:0] w2_8,
  input  logic [118:0] w2_9,
  input  logic [118:0] w2_10,
  input  logic [118:0] w2_11,
  input  logic [118:0] w2_12,
  input  logic [118:0] w2_13,
  input  logic [220:0] w_3,
  output logic [16:0]  y,
  output logic         y_valid
);

  // Sign-magnitude multiply: product magnitude is truncated after the Q8.8
  // realignment, saturated to 16 bits, and a zero magnitude is always +0.
  function automatic logic [16:0] sm_mul(input logic [16:0] a, input logic [16:0] b);
    logic [31:0] prod;
    logic [15:0] mag;
    prod = ({16'd0, a[15:0]} * {16'd0, b[15:0]}) >> 8;
    mag  = (|prod[31:16]) ? 16'hFFFF : prod[15:0];
    return (mag == 16'd0) ? 17'd0 : {a[16] ^ b[16], mag};
  endfunction

  function automatic logic signed [23:0] sm_to_tc(input logic [16:0] v);
    logic signed [23:0] m;
    m = {8'd0, v[15:0]};
    return v[16] ? -m : m;
  endfunction

  // Back to sign-magnitude with a saturated magnitude; never produces -0.
  function automatic logic [16:0] tc_to_sm(input logic signed [23:0] s);
    logic [23:0] m;
    logic [15:0] mag;
    m   = s[23] ? -s : s;
    mag = (|m[23:16]) ? 16'hFFFF : m[15:0];
    return (mag == 16'd0) ? 17'd0 : {s[23], mag};
  endfunction

  // Dot product over up to 13 lanes; unused lanes are fed zeros, which
  // multiply to +0. 13 saturated products fit easily within 24 bits.
  function automatic logic signed [23:0] dot13(input logic [220:0] acts, input logic [220:0] wts);
    logic signed [23:0] acc;
    acc = '0;
    for (int k = 0; k < 13; k++) begin
      acc = acc + sm_to_tc(sm_mul(acts[17*k +: 17], wts[17*k +: 17]));
    end
    return acc;
  endfunction

  logic [6:0][16:0]   x_pk;
  logic [6:0][16:0]   w_pk;
  logic [12:0][118:0] w2_pk;

  assign x_pk  = {x7, x6, x5, x4, x3, x2, x1};
  assign w_pk  = {w7, w6, w5, w4, w3, w2, w1};
  assign w2_pk = {w2_13, w2_12, w2_11, w2_10, w2_9, w2_8, w2_7,
                  w2_6, w2_5, w2_4, w2_3, w2_2, w2_1};

  // Weights for the later layers travel alongside the activations so each
  // stage only ever combines data belonging to the same input vector.
  logic [6:0][16:0]   a_q, a_d;
  logic [12:0][118:0] w2_s1_q, w2_s1_d;
  logic [220:0]       w3_s1_q, w3_s1_d;
  logic [12:0][16:0]  h_q, h_d;
  logic [220:0]       w3_s2_q, w3_s2_d;
  logic [16:0]        y_q, y_d;
  logic [2:0]         valid_q, valid_d;

  always_comb begin
    a_d     = '0;
    h_d     = '0;
    y_d     = '0;
    w2_s1_d = w2_pk;
    w3_s1_d = w_3;
    w3_s2_d = w3_s1_q;
    valid_d = {valid_q[1:0], 1'b1};

    for (int i = 0; i < 7; i++) begin
      a_d[i] = sm_mul(x_pk[i], w_pk[i]);
    end

    // ReLU: any negative sum becomes +0.
    for (int k = 0; k < 13; k++) begin
      logic signed [23:0] s2;
      s2     = dot13({102'd0, a_q}, {102'd0, w2_s1_q[k]});
      h_d[k] = s2[23] ? 17'd0 : tc_to_sm(s2);
    end

    y_d = tc_to_sm(dot13(h_q, w3_s2_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      w2_s1_q <= '0;
      w3_s1_q <= '0;
      h_q     <= '0;
      w3_s2_q <= '0;
      y_q     <= '0;
      valid_q <= '0;
    end else begin
      a_q     <= a_d;
      w2_s1_q <= w2_s1_d;
      w3_s1_q <= w3_s1_d;
      h_q     <= h_d;
      w3_s2_q <= w3_s2_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q[2];

endmodule

// File: tb/tb_mlp_main.sv
// tb_mlp_main
// Directed testbench for mlp_main: drives hand-computed vectors and checks
// y / y_valid three clock edges after each vector is sampled.

module tb_mlp_main;

  logic         clk;
  logic         rst;
  logic [16:0]  x1, x2, x3, x4, x5, x6, x7;
  logic [16:0]  w1, w2, w3, w4, w5, w6, w7;
  logic [118:0] w2_1, w2_2, w2_3, w2_4, w2_5, w2_6, w2_7;
  logic [118:0] w2_8, w2_9, w2_10, w2_11, w2_12, w2_13;
  logic [220:0] w_3;
  logic [16:0]  y;
  logic         y_valid;

  int compareCount;
  int failCount;

  mlp_main dut (
    .clk(clk), .rst(rst),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7),
    .w2_1(w2_1), .w2_2(w2_2), .w2_3(w2_3), .w2_4(w2_4), .w2_5(w2_5),
    .w2_6(w2_6), .w2_7(w2_7), .w2_8(w2_8), .w2_9(w2_9), .w2_10(w2_10),
    .w2_11(w2_11), .w2_12(w2_12), .w2_13(w2_13),
    .w_3(w_3),
    .y(y), .y_valid(y_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every x to xv, every wi to wv, every w2 lane to w2v, every w_3 lane to w3v.
  task automatic applyStimulus(input logic [16:0] xv, input logic [16:0] wv,
                               input logic [16:0] w2v, input logic [16:0] w3v);
    {x1, x2, x3, x4, x5, x6, x7} = {7{xv}};
    {w1, w2, w3, w4, w5, w6, w7} = {7{wv}};
    {w2_1, w2_2, w2_3, w2_4, w2_5, w2_6, w2_7} = {7{ {7{w2v}} }};
    {w2_8, w2_9, w2_10, w2_11, w2_12, w2_13}   = {6{ {7{w2v}} }};
    w_3 = {13{w3v}};
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] expY, input logic expValid);
    compareCount++;
    assert (y === expY) else begin
      failCount++;
      $error("[TB] FAIL %s y: observed %h expected %h", tag, y, expY);
    end
    compareCount++;
    assert (y_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s y_valid: observed %b expected %b", tag, y_valid, expValid);
    end
  endtask

  // Hold the current vector through the 3-edge latency, then check.
  task automatic runVector(input string tag, input logic [16:0] expY);
    step();
    step();
    step();
    checkOutput(tag, expY, 1'b1);
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;

    // Reset with the LSB vector (x2 negative): every product truncates to +0.
    rst = 1'b1;
    applyStimulus(17'h00001, 17'h00001, 17'h00001, 17'h00001);
    x2 = 17'h10001;
    step();
    step();
    checkOutput("reset", 17'h00000, 1'b0);

    rst = 1'b0;
    step();
    checkOutput("lsb_edge1", 17'h00000, 1'b0);
    step();
    checkOutput("lsb_edge2", 17'h00000, 1'b0);
    step();
    checkOutput("lsb_edge3", 17'h00000, 1'b1);

    // Unity path: h_k = 7.0, y = 13 * 7.0 = 91.0.
    applyStimulus(17'h00100, 17'h00100, 17'h00100, 17'h00100);
    runVector("unity", 17'h05B00);

    // All hidden sums -7.0 clamp to zero.
    applyStimulus(17'h00100, 17'h00100, 17'h10100, 17'h00100);
    runVector("relu_hidden", 17'h00000);

    // Linear output keeps the negative sign.
    applyStimulus(17'h00100, 17'h00100, 17'h00100, 17'h10100);
    runVector("neg_output", 17'h15B00);

    // Saturation at every stage.
    applyStimulus(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF);
    runVector("sat_pos", 17'h0FFFF);
    applyStimulus(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF);
    runVector("sat_neg", 17'h1FFFF);

    // Mixed output signs: 7 lanes at +1, 6 lanes at -1 -> 49 - 42 = 7.0.
    applyStimulus(17'h00100, 17'h00100, 17'h00100, 17'h00100);
    w_3 = {{6{17'h10100}}, {7{17'h00100}}};
    runVector("mixed_l3", 17'h00700);

    // a1 = -3/256 * 0.5 -> -1/256; times -1.0 -> +1/256; x2 = -0 contributes 0.
    applyStimulus(17'h00000, 17'h00000, 17'h00000, 17'h00000);
    x1   = 17'h10003;
    w1   = 17'h00080;
    x2   = 17'h10000;
    w2   = 17'h00100;
    w2_1 = {{6{17'h00000}}, 17'h10100};
    w_3  = {{12{17'h00000}}, 17'h00100};
    runVector("sign_lsb", 17'h00001);

    // 3.0 * 0x155 = 0x3FF (truncated); h1 = 0x3FF; times -2.0 -> -0x7FE.
    applyStimulus(17'h00000, 17'h00000, 17'h00000, 17'h00000);
    x1   = 17'h00300;
    w1   = 17'h00155;
    w2_1 = {{6{17'h00000}}, 17'h00100};
    w_3  = {{12{17'h00000}}, 17'h10200};
    runVector("truncate_neg", 17'h107FE);

    // Alternate unity / all-zero vectors every cycle; y follows 3 cycles later.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) applyStimulus(17'h00100, 17'h00100, 17'h00100, 17'h00100);
      else            applyStimulus(17'h00000, 17'h00000, 17'h00000, 17'h00000);
      step();
      if (i >= 2) begin
        checkOutput($sformatf("alternate_%0d", i), ((i - 2) % 2 == 0) ? 17'h05B00 : 17'h00000, 1'b1);
      end
    end

    // Reset for one cycle during a unity stream.
    applyStimulus(17'h00100, 17'h00100, 17'h00100, 17'h00100);
    runVector("pre_reset", 17'h05B00);
    rst = 1'b1;
    step();
    checkOutput("mid_reset", 17'h00000, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("post_reset_1", 17'h00000, 1'b0);
    step();
    checkOutput("post_reset_2", 17'h00000, 1'b0);
    step();
    checkOutput("post_reset_3", 17'h05B00, 1'b1);
    step();
    checkOutput("post_reset_4", 17'h05B00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/mlp_main.md
# mlp_main

Fixed-point feed-forward neural network core: 7 inputs, a per-input scaling layer, 13 hidden neurons with ReLU, and one linear output neuron. All weights and inputs are presented as parallel ports and sampled every clock. The block is fully pipelined, accepts a new input vector every cycle, and produces one result every cycle at fixed latency. It is the top-level compute block of the NN design; loading and storing weights are handled outside it.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- x1..x7  in  17 each  network inputs
- w1..w7  in  17 each  input-layer weights; wi scales xi
- w2_1..w2_13  in  119 each  hidden-neuron weights; w2_k[17*j+16:17*j] is the weight of input-layer output j+1 (j=0..6)
- w_3  in  221  output-neuron weights; w_3[17*k+16:17*k] is the weight of hidden neuron k+1 (k=0..12)
- y  out  17  network output
- y_valid  out  1  high when y holds a result computed from sampled inputs

## Operation
Number format for every 17-bit value:
- Sign-magnitude. Bit 16 is the sign (1 = negative); bits 15:0 are an unsigned Q8.8 magnitude, so 0x00100 = +1.0 and 0x10100 = -1.0.
- -0 (0x10000) is accepted as an input. Every produced value normalises -0 to +0 (0x00000).

Multiply, mul(a,b):
- sign = a[16] ^ b[16]
- magnitude = (a[15:0]*b[15:0]) >> 8, truncated toward zero
- saturate the magnitude to 0xFFFF
- a zero magnitude gives +0

Sum:
- Convert operands to two's complement and accumulate in at least 24 bits. Internal overflow is not allowed.
- Convert back to sign-magnitude, saturating the magnitude to 0xFFFF.

Layers:
- L1: a_i = mul(x_i, w_i), i=1..7. No activation.
- L2: h_k = ReLU(sum_j mul(a_j, w2_k[j])), k=1..13. ReLU maps any negative result to +0.
- L3: y = sum_k mul(h_k, w_3[k]). Linear output, saturated, no activation.

## Timing
- Three pipeline register stages: L1 results, L2 results, y.
- Latency: inputs sampled at edge n produce y after edge n+3.
- Throughput: one input vector per cycle. There is no stall or handshake, and inputs are sampled every cycle.
- y_valid is a 3-bit shift register fed with 1.
  - rst clears it.
  - It goes high after the 3rd edge following rst deassertion and then stays high.
- On rst at any edge:
  - all pipeline registers clear to 0, so y = 0x00000 and y_valid = 0 on the next cycle;
  - in-flight data is discarded;
  - reset asserted mid-stream behaves identically.
- Inputs that change every cycle must produce independent results, each exactly 3 cycles later. Stages must not mix data from different vectors.

## Test plan
- LSB stimulus: every x, w, w2 word and w_3 word is 0x00001 (x2 = 0x10001, i.e. negative). All products truncate to 0 -> y = 0x00000, y_valid high from cycle 3 after rst release.
- Unity path: all x, wi, w2 and w_3 weights = +1.0 (0x00100) -> a_i = 1.0, h_k = 7.0, y = 91.0 = 0x05B00 at latency 3.
- ReLU: as the unity path but all w2 weights = -1.0 (0x10100) -> all h_k = 0, y = 0x00000. Then as the unity path with only w_3 weights = -1.0 -> y = 0x15B00.
- Saturation: all x and w at +255.996 (0x0FFFF) -> every stage saturates and y = 0x0FFFF. The same with the w_3 signs negated -> y = 0x1FFFF.
- Pipelining: apply the unity vector and the all-zero vector on alternating cycles -> y alternates 0x05B00 / 0x00000 with 3-cycle delay.
- Reset mid-stream: assert rst for 1 cycle during the unity stream -> y = 0 and y_valid = 0 the next cycle. y_valid returns high exactly 3 edges after release, with y = 0x05B00.
